// File: rtl/score_scroll_ctrl_if.sv
// Control/status bundle between the game-over logic and the grade-scroll controller.
// master drives VS/start/final_grade/clear; slave (the controller) drives the glyph outputs.
interface score_scroll_ctrl_if;
   logic       VS;
   logic       start;
   logic [3:0] final_grade;
   logic       clear;
   logic [3:0] letter;
   logic       show_score;
   logic       busy;
   logic       done;

   modport master (
      output VS, start, final_grade, clear,
      input  letter, show_score, busy, done
   );

   modport slave (
      input  VS, start, final_grade, clear,
      output letter, show_score, busy, done
   );
endinterface

// File: rtl/score_scroll_ctrl.sv
// Slot-machine style grade scroll: fast laps, then decelerating steps to the final grade, hold, done.
// All outputs registered; letter moves one cycle after the VS falling edge that triggers a step.
module score_scroll_ctrl #(
   parameter int NUM_LETTERS = 6,
   parameter int FAST_LAPS   = 2,
   parameter int FAST_DIV    = 2,
   parameter int SLOW_INC    = 2,
   parameter int HOLD_FRAMES = 60
) (
   input  logic                Clk,
   input  logic                Reset_n,
   score_scroll_ctrl_if.slave  bus
);

   localparam int         HW   = ($clog2(HOLD_FRAMES + 1) > 8) ? $clog2(HOLD_FRAMES + 1) : 8;
   localparam logic [3:0] LAST = 4'(NUM_LETTERS - 1);

   typedef enum logic [2:0] {IDLE, FAST, SLOW, HOLD, DONE} state_t;

   state_t        state_q, state_d;
   logic          vs_q;
   logic          frame_evt;
   logic [3:0]    letter_q, letter_d;
   logic [3:0]    target_q, target_d;
   logic [3:0]    letter_nxt;
   logic [7:0]    lap_q, lap_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic [5:0]    period_q, period_d;
   logic [6:0]    period_sum;
   logic [HW-1:0] hold_q, hold_d;
   logic          show_q, busy_q, done_q;

   assign frame_evt  = vs_q & ~bus.VS;
   assign letter_nxt = (letter_q == LAST) ? 4'd0 : letter_q + 4'd1;
   assign period_sum = {1'b0, period_q} + 7'(SLOW_INC);

   always_comb begin
      state_d     = state_q;
      letter_d    = letter_q;
      target_d    = target_q;
      lap_d       = lap_q;
      frame_cnt_d = frame_cnt_q;
      period_d    = period_q;
      hold_d      = hold_q;

      if (bus.clear) begin
         state_d     = IDLE;
         letter_d    = 4'd0;
         target_d    = 4'd0;
         lap_d       = 8'd0;
         frame_cnt_d = 8'd0;
         period_d    = 6'd0;
         hold_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d     = FAST;
                  target_d    = (bus.final_grade > LAST) ? LAST : bus.final_grade;
                  letter_d    = 4'd0;
                  lap_d       = 8'd0;
                  frame_cnt_d = 8'd0;
                  period_d    = 6'(FAST_DIV);
                  hold_d      = '0;
               end
            end
            FAST, SLOW: begin
               if (frame_evt) begin
                  if (frame_cnt_q + 8'd1 == {2'b00, period_q}) begin
                     frame_cnt_d = 8'd0;
                     letter_d    = letter_nxt;
                     if (state_q == FAST) begin
                        // lap completes on the LAST -> 0 wrap
                        if (letter_q == LAST) begin
                           lap_d = lap_q + 8'd1;
                           if (lap_q + 8'd1 == 8'(FAST_LAPS)) begin
                              hold_d = '0;
                              if (target_q == 4'd0) begin
                                 state_d = HOLD;
                              end else begin
                                 state_d  = SLOW;
                                 period_d = 6'(FAST_DIV + SLOW_INC);
                              end
                           end
                        end
                     end else begin
                        period_d = (period_sum > 7'd63) ? 6'd63 : period_sum[5:0];
                        if (letter_nxt == target_q) begin
                           state_d = HOLD;
                           hold_d  = '0;
                        end
                     end
                  end else begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end
            end
            HOLD: begin
               if (frame_evt) begin
                  if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                     state_d = DONE;
                  end else begin
                     hold_d = hold_q + 1'b1;
                  end
               end
            end
            DONE: begin
               letter_d = target_q;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         vs_q        <= 1'b1;
         letter_q    <= 4'd0;
         target_q    <= 4'd0;
         lap_q       <= 8'd0;
         frame_cnt_q <= 8'd0;
         period_q    <= 6'd0;
         hold_q      <= '0;
         show_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= bus.VS;
         letter_q    <= letter_d;
         target_q    <= target_d;
         lap_q       <= lap_d;
         frame_cnt_q <= frame_cnt_d;
         period_q    <= period_d;
         hold_q      <= hold_d;
         show_q      <= (state_d != IDLE);
         busy_q      <= (state_d == FAST) || (state_d == SLOW) || (state_d == HOLD);
         done_q      <= (state_d == DONE);
      end
   end

   assign bus.letter     = letter_q;
   assign bus.show_score = show_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_score_scroll_ctrl.sv
// Randomized bench for score_scroll_ctrl against a frame-schedule reference model.
module tb_score_scroll_ctrl;

   localparam int NL = 6;
   localparam int FL = 2;
   localparam int FD = 2;
   localparam int SI = 2;
   localparam int HF = 60;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;

   score_scroll_ctrl_if bus ();

   score_scroll_ctrl #(
      .NUM_LETTERS (NL),
      .FAST_LAPS   (FL),
      .FAST_DIV    (FD),
      .SLOW_INC    (SI),
      .HOLD_FRAMES (HF)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference schedule: frame number -> letter shown after that frame's step
   int step_let[int];
   int tgt;
   int done_f;
   int cur_let;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic void build(input int grade);
      int f;
      int p;
      step_let.delete();
      tgt = (grade > NL - 1) ? NL - 1 : grade;
      for (int k = 1; k <= NL * FL; k++) step_let[FD * k] = k % NL;
      f = FD * NL * FL;
      p = FD;
      for (int j = 1; j <= tgt; j++) begin
         p = (p + SI > 63) ? 63 : p + SI;
         f = f + p;
         step_let[f] = j;
      end
      done_f = f + HF;
   endfunction

   // Called just after a rising edge; returns just after a rising edge.
   task automatic frame();
      int k;
      int m;
      k = $urandom_range(1, 2);
      m = $urandom_range(1, 3);
      bus.VS = 1'b0;
      repeat (k) @(posedge Clk);
      #1 bus.VS = 1'b1;
      repeat (m) @(posedge Clk);
      #1;
   endtask

   task automatic do_start(input int grade);
      bus.start       = 1'b1;
      bus.final_grade = 4'(grade);
      @(posedge Clk);
      #1 bus.start    = 1'b0;
      bus.final_grade = 4'($urandom_range(0, 15));
      cur_let         = 0;
      @(negedge Clk);
      check("start_letter", int'(bus.letter), 0);
      check("start_busy", int'(bus.busy), 1);
      check("start_show", int'(bus.show_score), 1);
      @(posedge Clk);
      #1;
   endtask

   task automatic run_frames(input string tag, input int from, input int to, output int first_done);
      first_done = -1;
      for (int n = from; n <= to; n++) begin
         frame();
         if (step_let.exists(n)) cur_let = step_let[n];
         @(negedge Clk);
         check($sformatf("%s_let_f%0d", tag, n), int'(bus.letter), cur_let);
         check($sformatf("%s_busy_f%0d", tag, n), int'(bus.busy), (n < done_f) ? 1 : 0);
         check($sformatf("%s_done_f%0d", tag, n), int'(bus.done), (n >= done_f) ? 1 : 0);
         check($sformatf("%s_show_f%0d", tag, n), int'(bus.show_score), 1);
         if (first_done < 0 && bus.done) first_done = n;
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge Clk);
      check({tag, "_letter"}, int'(bus.letter), 0);
      check({tag, "_show"}, int'(bus.show_score), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int fd;
      int g;
      bus.VS          = 1'b1;
      bus.start       = 1'b0;
      bus.clear       = 1'b0;
      bus.final_grade = 4'd0;
      cur_let         = 0;
      #1;
      check("rst_letter", int'(bus.letter), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_show", int'(bus.show_score), 0);
      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      check_idle("idle");

      // grade 3: slow approach, done after frame 102
      build(3);
      do_start(3);
      run_frames("g3", 1, done_f + 2, fd);
      check("g3_done_frame", fd, 102);
      check("g3_final_letter", int'(bus.letter), 3);

      // done + simultaneous start/clear: clear wins, start dropped
      bus.start = 1'b1; bus.clear = 1'b1; bus.final_grade = 4'd2;
      @(posedge Clk);
      #1 bus.start = 1'b0; bus.clear = 1'b0;
      check_idle("done_clr");
      for (int i = 0; i < 3; i++) begin
         frame();
         check_idle("done_clr_after");
      end

      // grade 0: fast straight to hold
      build(0);
      do_start(0);
      run_frames("g0", 1, done_f + 1, fd);
      check("g0_done_frame", fd, 84);
      bus.clear = 1'b1;
      @(posedge Clk);
      #1 bus.clear = 1'b0;
      check_idle("g0_clr");

      // grade 9 clamps to last glyph
      build(9);
      do_start(9);
      run_frames("g9", 1, done_f + 1, fd);
      check("g9_clamp_letter", int'(bus.letter), 5);
      check("g9_clamp_done", int'(bus.done), 1);
      bus.clear = 1'b1;
      @(posedge Clk);
      #1 bus.clear = 1'b0;

      // clear at frame 10, coincident with a frame event
      g = $urandom_range(0, 15);
      build(g);
      do_start(g);
      run_frames("clr", 1, 9, fd);
      bus.VS = 1'b0; bus.clear = 1'b1;
      @(posedge Clk);
      #1 bus.clear = 1'b0;
      check_idle("clr_f10");
      bus.VS = 1'b1;
      @(posedge Clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         frame();
         check_idle("clr_after");
      end
      build(4);
      do_start(4);
      run_frames("restart", 1, done_f, fd);
      bus.clear = 1'b1;
      @(posedge Clk);
      #1 bus.clear = 1'b0;

      // second start during FAST must not retarget
      build(2);
      do_start(2);
      run_frames("restart2", 1, 5, fd);
      bus.start = 1'b1; bus.final_grade = 4'd5;
      @(posedge Clk);
      #1 bus.start = 1'b0;
      @(negedge Clk);
      check("restart2_busy", int'(bus.busy), 1);
      check("restart2_letter", int'(bus.letter), cur_let);
      @(posedge Clk);
      #1;
      run_frames("restart2", 6, done_f + 1, fd);
      check("restart2_target", int'(bus.letter), 2);
      bus.clear = 1'b1;
      @(posedge Clk);
      #1 bus.clear = 1'b0;

      // random grades
      for (int r = 0; r < 3; r++) begin
         g = $urandom_range(0, 15);
         build(g);
         do_start(g);
         run_frames($sformatf("rnd%0d", r), 1, done_f + 1, fd);
         check($sformatf("rnd%0d_done_frame", r), fd, done_f);
         bus.clear = 1'b1;
         @(posedge Clk);
         #1 bus.clear = 1'b0;
      end

      // reset mid-SLOW with VS held low across release
      build(4);
      do_start(4);
      run_frames("pre_rst", 1, 30, fd);
      bus.VS = 1'b0;
      #2 Reset_n = 1'b0;
      #1;
      check("arst_letter", int'(bus.letter), 0);
      check("arst_busy", int'(bus.busy), 0);
      check("arst_done", int'(bus.done), 0);
      check("arst_show", int'(bus.show_score), 0);
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      check_idle("post_rst");
      build(1);
      do_start(1);
      repeat (4) @(posedge Clk);
      @(negedge Clk);
      check("vs_low_no_step", int'(bus.letter), 0);
      check("vs_low_busy", int'(bus.busy), 1);
      @(posedge Clk);
      #1 bus.VS = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      run_frames("post_rst", 1, done_f, fd);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/score_scroll_ctrl.md
SCORE_SCROLL_CTRL -- requirements
Module: score_scroll_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_LETTERS, 6, number of grade glyphs, indices 0..NUM_LETTERS-1.
- FAST_LAPS, 2, full fast revolutions before deceleration.
- FAST_DIV, 2, frames per step in fast phase.
- SLOW_INC, 2, frames added to the step period after each slow step.
- HOLD_FRAMES, 60, frames to hold the final glyph before done.
REQ-002 Ports (name, direction, width, meaning):
- Clk, in, 1, single system clock.
- Reset_n, in, 1, reset: asynchronous, active-low.
- VS, in, 1, VGA vertical sync, active-low.
- start, in, 1, one-cycle pulse: game over, begin scroll.
- final_grade, in, 4, target glyph index, sampled on the accepted start.
- clear, in, 1, one-cycle pulse: abort or acknowledge, return to idle.
- letter, out, 4, glyph index driven to the score glyph address generator.
- show_score, out, 1, score glyph display enable.
- busy, out, 1, high in FAST, SLOW and HOLD.
- done, out, 1, high only in DONE.

Function
REQ-003 Frame event: a one-cycle internal pulse on each VS falling edge, detected from a registered copy of VS; all step timing counts frame events only.
REQ-004 States: IDLE, FAST, SLOW, HOLD, DONE; all transitions registered on Clk rising edge.
REQ-005 IDLE: letter=0, show_score=0, busy=0, done=0. start=1 moves to FAST next cycle.
REQ-006 On the accepted start:
- Latch target = min(final_grade, NUM_LETTERS-1).
- Set letter=0, lap=0, frame_cnt=0, period=FAST_DIV.
REQ-007 start SHALL be ignored in every state except IDLE; final_grade is not re-sampled while busy.
REQ-008 Step rule (FAST/SLOW):
- frame_cnt increments on each frame event.
- When a frame event brings frame_cnt to period: take one step and zero frame_cnt.
- A step sets letter=(letter+1) mod NUM_LETTERS.
REQ-009 FAST: a step wrapping NUM_LETTERS-1 to 0 increments lap. On the wrap making lap=FAST_LAPS:
- target==0: go to HOLD.
- otherwise: go to SLOW with period=FAST_DIV+SLOW_INC.
REQ-010 SLOW: after each step, period += SLOW_INC, saturating at 63 (6-bit). A step that makes letter==target goes to HOLD.
REQ-011 HOLD: letter frozen at target; count HOLD_FRAMES frame events, then go to DONE.
REQ-012 DONE: letter=target, show_score=1, done=1; remain until clear.
REQ-013 show_score=1 in FAST, SLOW, HOLD and DONE.
REQ-014 clear=1 in any state returns to IDLE next cycle and zeroes all counters. clear has priority over start and over a simultaneous frame event.
REQ-015 Output timing: letter, busy, done and show_score are registered outputs, with no combinational path from inputs. letter changes in the cycle after the frame event that causes a step.
REQ-016 Widths: internal counters are at least 8 bits (HOLD counter sized for HOLD_FRAMES); none wrap within a legal sequence.

Reset
REQ-017 Reset_n=0 asynchronously forces:
- state=IDLE, letter=0, show_score=0, busy=0, done=0.
- All counters=0; registered VS copy=1, so no spurious frame event on release.
REQ-018 Reset mid-scroll abandons the sequence. After release, the block waits in IDLE for a new start.

Verification
REQ-019 Frame numbers count frame events after start.
- start with final_grade=3. Expected: letter=0 at frame 24 and the state enters SLOW. Then letter=1 at frame 28, 2 at 34, 3 at 42 (HOLD). done=1 after frame 102.
- start with final_grade=0. Expected: direct FAST to HOLD at frame 24 with letter=0; done=1 after frame 84.
- start with final_grade=9. Expected: target clamped to 5; letter=5 in DONE.
- clear pulsed at frame 10 during FAST. Expected: IDLE next cycle, letter=0, show_score=0. A later start restarts from letter 0.
- In DONE, drive start and clear in the same cycle. Expected: IDLE, and the start is not accepted. A second start pulsed in FAST is ignored and the target is unchanged.
- Assert Reset_n low mid-SLOW with VS held low across release. Expected: all outputs 0 immediately, and no frame event or step until the next VS falling edge after a start.
